// File: rtl/ds1302_time_sched.sv
// Request scheduler in front of the DS1302 controller: periodic polling, queued set-time writes
// with mandatory read-back, stall timeout. Optional set_time validation: DS1302_SET_CHECK_EN.
module ds1302_time_sched #(
  parameter int POLL_CYCLES    = 5_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        set_req_i,
  input  logic [55:0] set_time_i,
  output logic        write_time_req_o,
  input  logic        write_time_ack_i,
  output logic [55:0] wr_time_o,
  output logic        read_time_req_o,
  input  logic        read_time_ack_i,
  input  logic [55:0] rd_time_i,
  output logic [55:0] time_bcd_o,
  output logic        time_valid_o,
  output logic        sec_tick_o,
  output logic        busy_o,
`ifdef DS1302_SET_CHECK_EN
  output logic        set_err_o,
`endif
  output logic        timeout_err_o
);

  localparam int PW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // sec[7] is clock-halt, hour[7] selects 12h mode; both are kept at 0.
  localparam logic [55:0] CTRL_MASK = 56'h00_00_00_00_80_00_80;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_CAPT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]    hold_q, hold_d;
  logic          set_pend_q, set_pend_d;
  logic          poll_pend_q, poll_pend_d;
  logic [55:0]   wr_time_q, wr_time_d;
  logic [55:0]   shd_q, shd_d;
  logic          shd_vld_q, shd_vld_d;
  logic [55:0]   time_bcd_q, time_bcd_d;
  logic          time_valid_q, time_valid_d;
  logic          sec_tick_q, sec_tick_d;
  logic          tmo_err_q, tmo_err_d;

  logic [55:0] set_masked, rd_masked;
  logic        poll_wrap, tmo_hit, set_acc;

  assign set_masked = set_time_i & ~CTRL_MASK;
  assign rd_masked  = rd_time_i & ~CTRL_MASK;
  assign poll_wrap  = (poll_cnt_q == PW'(POLL_CYCLES - 1));
  assign tmo_hit    = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

`ifdef DS1302_SET_CHECK_EN
  logic set_err_q, set_err_d;

  function automatic logic time_ok(input logic [55:0] t);
    logic ok;
    ok = 1'b1;
    for (int n = 0; n < 14; n++)
      if (t[n*4 +: 4] > 4'd9) ok = 1'b0;
    if (t[7:0]   > 8'h59)                    ok = 1'b0;
    if (t[15:8]  > 8'h59)                    ok = 1'b0;
    if (t[23:16] > 8'h23)                    ok = 1'b0;
    if (t[31:24] < 8'h01 || t[31:24] > 8'h31) ok = 1'b0;
    if (t[39:32] < 8'h01 || t[39:32] > 8'h12) ok = 1'b0;
    if (t[47:40] < 8'h01 || t[47:40] > 8'h07) ok = 1'b0;
    return ok;
  endfunction

  // Validation runs on the masked value so control bits never cause a reject.
  assign set_acc   = set_req_i & time_ok(set_masked);
  assign set_err_d = set_req_i & ~time_ok(set_masked);
  assign set_err_o = set_err_q;
`else
  assign set_acc = set_req_i;
`endif

  always_comb begin
    state_d      = state_q;
    poll_cnt_d   = poll_wrap ? '0 : poll_cnt_q + PW'(1);
    hold_d       = hold_q;
    set_pend_d   = set_pend_q;
    poll_pend_d  = poll_pend_q | poll_wrap;
    wr_time_d    = wr_time_q;
    shd_d        = shd_q;
    shd_vld_d    = shd_vld_q;
    time_bcd_d   = time_bcd_q;
    time_valid_d = time_valid_q;
    sec_tick_d   = 1'b0;
    tmo_err_d    = tmo_err_q;

    // Outside WR a new set overwrites the pending one directly; in WR it is shadowed.
    if (set_acc && state_q != S_WR) begin
      wr_time_d  = set_masked;
      set_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (hold_q != 4'd0)                  hold_d  = hold_q - 4'd1;
        else if (set_pend_q || set_acc)      state_d = S_WR;
        else if (poll_pend_q || poll_wrap)   state_d = S_RD;
      end
      S_WR: begin
        if (set_acc) begin
          shd_d     = set_masked;
          shd_vld_d = 1'b1;
        end
        if (write_time_ack_i || tmo_hit) begin
          if (set_acc)        wr_time_d = set_masked;
          else if (shd_vld_q) wr_time_d = shd_q;
          shd_vld_d = 1'b0;
          if (write_time_ack_i) begin
            set_pend_d = set_acc | shd_vld_q;
            state_d    = S_RD;
          end else begin
            state_d     = S_IDLE;
            tmo_err_d   = 1'b1;
            poll_pend_d = poll_wrap;
            hold_d      = 4'd15;
          end
        end
      end
      S_RD: begin
        // Snapshot is taken on the ack edge so it is visible during CAPT.
        if (read_time_ack_i) begin
          poll_pend_d  = poll_wrap;
          time_bcd_d   = rd_masked;
          sec_tick_d   = !time_valid_q || (rd_masked[7:0] != time_bcd_q[7:0]);
          time_valid_d = 1'b1;
          tmo_err_d    = 1'b0;
          state_d      = S_CAPT;
        end else if (tmo_hit) begin
          state_d     = S_IDLE;
          tmo_err_d   = 1'b1;
          poll_pend_d = poll_wrap;
          hold_d      = 4'd15;
        end
      end
      S_CAPT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    tmo_cnt_d = '0;
    if (state_d == state_q && (state_q == S_WR || state_q == S_RD))
      tmo_cnt_d = tmo_cnt_q + TW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      poll_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      hold_q       <= '0;
      set_pend_q   <= 1'b0;
      poll_pend_q  <= 1'b0;
      wr_time_q    <= '0;
      shd_q        <= '0;
      shd_vld_q    <= 1'b0;
      time_bcd_q   <= '0;
      time_valid_q <= 1'b0;
      sec_tick_q   <= 1'b0;
      tmo_err_q    <= 1'b0;
`ifdef DS1302_SET_CHECK_EN
      set_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      poll_cnt_q   <= poll_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      hold_q       <= hold_d;
      set_pend_q   <= set_pend_d;
      poll_pend_q  <= poll_pend_d;
      wr_time_q    <= wr_time_d;
      shd_q        <= shd_d;
      shd_vld_q    <= shd_vld_d;
      time_bcd_q   <= time_bcd_d;
      time_valid_q <= time_valid_d;
      sec_tick_q   <= sec_tick_d;
      tmo_err_q    <= tmo_err_d;
`ifdef DS1302_SET_CHECK_EN
      set_err_q    <= set_err_d;
`endif
    end
  end

  // Requests decode straight from state, so they drop on the ack edge.
  assign write_time_req_o = (state_q == S_WR);
  assign read_time_req_o  = (state_q == S_RD);
  assign busy_o           = (state_q != S_IDLE);
  assign wr_time_o        = wr_time_q;
  assign time_bcd_o       = time_bcd_q;
  assign time_valid_o     = time_valid_q;
  assign sec_tick_o       = sec_tick_q;
  assign timeout_err_o    = tmo_err_q;

endmodule
